// File: rtl/mem_arb_pkg.sv
// Shared state/owner encodings and default widths for the fetch/data memory port arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;
endpackage

// File: rtl/arb_perf_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module arb_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of one single-port memory; optional performance
// counters are built only when ARB_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | no access in flight; a pending request is granted at the next edge
// ACCESS | mem_en held for MEM_LAT cycles from latched owner/addr/we/wdata
// RESP   | one-cycle ack to the owner; no new grant from here
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm,
    output logic [15:0]       perf_conflict,
    output logic [15:0]       perf_busy
);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t        state, state_nx;
    owner_t            owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LW-1:0]     lat_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              grant;
    logic              grant_if;

    // Fetch only beats a concurrent data request once it has lost STARVE_MAX times in a row.
    assign grant_if = if_req & (~dm_req | ((STARVE_MAX != 0) && (starve_cnt == STARVE_TOP)));

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        mem_en   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    grant    = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                if (lat_cnt == '0) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner   <= grant_if ? OWN_IF : OWN_DM;
                addr_q  <= grant_if ? if_addr : dm_addr;
                we_q    <= grant_if ? 1'b0 : dm_we;
                wdata_q <= grant_if ? '0 : dm_wdata;
                lat_cnt <= LAT_LOAD;
                if (grant_if) begin
                    starve_cnt <= '0;
                end else if (if_req && (starve_cnt != STARVE_TOP)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
            if (state == ACCESS) begin
                if (lat_cnt != '0) begin
                    lat_cnt <= lat_cnt - 1'b1;
                end else if (owner == OWN_IF) begin
                    if_rdata <= mem_rdata;
                end else if (!we_q) begin
                    dm_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_ack    = (state == RESP) && (owner == OWN_IF);
    assign dm_ack    = (state == RESP) && (owner == OWN_DM);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stall_if  = if_req & ~if_ack;
    assign stall_dm  = dm_req & ~dm_ack;

`ifdef ARB_PERF_CNT_EN
    arb_perf_counter u_perf_conflict (
        .clk   (clk),
        .rst   (rst),
        .inc   ((state == IDLE) && if_req && dm_req),
        .count (perf_conflict)
    );

    arb_perf_counter u_perf_busy (
        .clk   (clk),
        .rst   (rst),
        .inc   (state != IDLE),
        .count (perf_busy)
    );
`else
    assign perf_conflict = 16'h0000;
    assign perf_busy     = 16'h0000;
`endif
endmodule
